mb8_arb: RTL and testbench

Two-requester arbiter and access sequencer for the 8-bit, 128 KB single-port memory (spram8_128k on the mb8_io interface). The instruction-fetch and data-access ports of the eForth1 core each issue 8-bit or 16-bit requests. The block grants one requester at a time, round-robin, and splits 16-bit cells into two big-endian byte cycles on the memory port. It is the only master of the mb8_io slave.

---
 rtl/mb8_pkg.sv | 27 ++
 rtl/mb8_arb_rr_arb2.sv | 37 +++
 rtl/mb8_arb.sv | 111 +++++++++++
 tb/tb_mb8_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mb8_pkg.sv
// mb8_pkg: shared types and sizes for the mb8 memory arbiter slice.
//   ASZ / DSZ : memory address / data width (128 KB, byte-wide)
//   addr_t    : byte address on the memory port
//   st_t      : access sequencer states
//   req_t     : one requester's latched command
package mb8_pkg;

  localparam int unsigned ASZ = 17;
  localparam int unsigned DSZ = 8;

  typedef logic [ASZ-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    A0   = 2'd1,
    A1   = 2'd2,
    TL   = 2'd3
  } st_t;

  typedef struct packed {
    logic        we;
    logic        wide;
    addr_t       addr;
    logic [15:0] wdata;
  } req_t;

endpackage

// File: rtl/mb8_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_i[1:0]   : request vector
//   upd_i        : acceptance strobe; the last-grant pointer moves only
//                  when this is high and some request is present
//   gnt_idx_o    : index of the winning requester
//   vld_o        : high when any request is present
// The pointer resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       gnt_idx_o,
  output logic       vld_o
);

  logic last_q;

  always_comb begin
    vld_o = |req_i;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_q;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd_i && vld_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/mb8_arb.sv
// mb8_arb: two-requester arbiter and access sequencer for a byte-wide
// single-port memory with registered read data.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_i/we_i/wide_i : per-requester request, write enable, 16-bit size
//   addr_i, wdata_i   : per-requester byte address and write data
//   ack_o, rdata_o    : one-cycle completion strobe and read data
//   busy_o            : sequencer not idle
//   mem_ai/mem_vi/mem_we/mem_vo : memory master port
// 16-bit cells are big-endian: high byte at addr, low byte at addr+1.
module mb8_arb
  import mb8_pkg::*;
#(
  parameter int unsigned ASZ = mb8_pkg::ASZ,
  parameter int unsigned DSZ = mb8_pkg::DSZ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [1:0]            wide_i,
  input  logic [1:0][ASZ-1:0]   addr_i,
  input  logic [1:0][2*DSZ-1:0] wdata_i,
  output logic [1:0]            ack_o,
  output logic [2*DSZ-1:0]      rdata_o,
  output logic                  busy_o,
  output logic [ASZ-1:0]        mem_ai,
  output logic [DSZ-1:0]        mem_vi,
  output logic                  mem_we,
  input  logic [DSZ-1:0]        mem_vo
);

  st_t                st_q, st_d;
  logic               we_q, wide_q, gnt_q;
  logic [ASZ-1:0]     addr_q;
  logic [2*DSZ-1:0]   wdata_q;
  logic [DSZ-1:0]     hi_q;
  logic               gnt_idx, gnt_vld, accept;

  assign accept = (st_q == IDLE) && gnt_vld;

  rr_arb2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .upd_i     (st_q == IDLE),
    .gnt_idx_o (gnt_idx),
    .vld_o     (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      we_q    <= 1'b0;
      wide_q  <= 1'b0;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        we_q    <= we_i[gnt_idx];
        wide_q  <= wide_i[gnt_idx];
        addr_q  <= addr_i[gnt_idx];
        wdata_q <= wdata_i[gnt_idx];
        gnt_q   <= gnt_idx;
      end
      // mem_vo in A1 carries the byte addressed during A0 (the high byte)
      if (st_q == A1) begin
        hi_q <= mem_vo;
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    mem_ai  = addr_q;
    mem_vi  = '0;
    mem_we  = 1'b0;
    ack_o   = '0;
    rdata_o = '0;
    busy_o  = (st_q != IDLE);
    unique case (st_q)
      IDLE: begin
        if (gnt_vld) st_d = A0;
      end
      A0: begin
        mem_we = we_q;
        mem_vi = wide_q ? wdata_q[2*DSZ-1:DSZ] : wdata_q[DSZ-1:0];
        st_d   = wide_q ? A1 : TL;
      end
      A1: begin
        mem_ai = addr_q + ASZ'(1);
        mem_we = we_q;
        mem_vi = wdata_q[DSZ-1:0];
        st_d   = TL;
      end
      TL: begin
        if (wide_q) mem_ai = addr_q + ASZ'(1);
        ack_o[gnt_q] = 1'b1;
        rdata_o      = wide_q ? {hi_q, mem_vo} : {{DSZ{1'b0}}, mem_vo};
        st_d         = IDLE;
      end
      default: st_d = IDLE;
    endcase
    // A reset arriving mid-access must suppress the write on that same
    // edge, so the strobe is qualified by rst_n rather than waiting for state.
    if (!rst_n) mem_we = 1'b0;
  end

endmodule

// File: tb/tb_mb8_arb.sv
module tb_mb8_arb;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req, we, wide;
  logic [1:0][16:0] addr;
  logic [1:0][15:0] wdata;
  logic [1:0]       ack_o;
  logic [15:0]      rdata_o;
  logic             busy_o;
  logic [16:0]      mem_ai;
  logic [7:0]       mem_vi;
  logic             mem_we;
  logic [7:0]       mem_vo;

  logic [7:0] mem [0:131071];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int we_cnt = 0;

  typedef struct {
    int          idx;
    bit          rd;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  mb8_arb #(.ASZ(17), .DSZ(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .we_i    (we),
    .wide_i  (wide),
    .addr_i  (addr),
    .wdata_i (wdata),
    .ack_o   (ack_o),
    .rdata_o (rdata_o),
    .busy_o  (busy_o),
    .mem_ai  (mem_ai),
    .mem_vi  (mem_vi),
    .mem_we  (mem_we),
    .mem_vo  (mem_vo)
  );

  always #5 clk = ~clk;

  // spram8_128k behaviour: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_we) mem[mem_ai] <= mem_vi;
    mem_vo <= mem[mem_ai];
    cyc    <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt = we_cnt + 1;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && ack_o != 2'b00) begin
      n_chk++;
      if (ack_o == 2'b11 || sb.size() == 0) begin
        $display("FAIL ack_unexpected got=%b want=one-hot expected ack", ack_o);
      end else begin
        e = sb.pop_front();
        if (ack_o != (2'b01 << e.idx) || (e.rd && rdata_o !== e.data))
          $display("FAIL ack_data got ack=%b rdata=%h want ack=%b rdata=%h",
                   ack_o, rdata_o, 2'b01 << e.idx, e.data);
        else
          n_pass++;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, act, exp);
  endtask

  task automatic push(input int i, input bit rd, input logic [15:0] d);
    exp_t x;
    x.idx = i; x.rd = rd; x.data = d;
    sb.push_back(x);
  endtask

  task automatic do_req(input int i, input bit w, input bit wd,
                        input logic [16:0] a, input logic [15:0] d, output int lat);
    int start;
    bit got;
    we[i] = w; wide[i] = wd; addr[i] = a; wdata[i] = d;
    req[i] = 1'b1;
    start = cyc;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ack_o[i]) begin got = 1; break; end
    end
    lat = cyc - start;
    if (!got) begin
      n_chk++;
      $display("FAIL ack_timeout req%0d got=none want=ack", i);
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  initial begin
    int lat0, lat1, w0;
    for (int a = 0; a < 131072; a++) mem[a] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      mem[17'h40 + k] = 8'h50 + 8'(k);
      mem[17'h80 + k] = 8'h90 + 8'(k);
    end
    rst_n = 1'b0; req = '0; we = '0; wide = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",   {31'd0, busy_o}, 32'd0);
    check("rst_ack",    {30'd0, ack_o},  32'd0);
    check("rst_rdata",  {16'd0, rdata_o}, 32'd0);
    check("rst_memwe",  {31'd0, mem_we}, 32'd0);
    check("rst_memai",  {15'd0, mem_ai}, 32'd0);
    check("rst_memvi",  {24'd0, mem_vi}, 32'd0);

    // Contention from reset: strict 0,1,0,1 alternation
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      push(0, 1, 16'h0050 + 16'(k));
      push(1, 1, 16'h0090 + 16'(k));
    end
    fork
      for (int k = 0; k < 4; k++) do_req(0, 0, 0, 17'h40 + 17'(k), 16'h0, lat0);
      for (int k = 0; k < 4; k++) do_req(1, 0, 0, 17'h80 + 17'(k), 16'h0, lat1);
    join

    // Lone requester 1 granted every time
    for (int k = 0; k < 3; k++) begin
      push(1, 1, 16'h0090 + 16'(k));
      do_req(1, 0, 0, 17'h80 + 17'(k), 16'h0, lat1);
    end

    // Byte write then read
    @(posedge clk); #1;
    w0 = we_cnt;
    push(0, 0, 16'h0);
    do_req(0, 1, 0, 17'h00010, 16'h00A5, lat0);
    check("bw_lat", lat0, 2);
    check("bw_wecycles", we_cnt - w0, 1);
    check("bw_mem", {24'd0, mem[17'h00010]}, 32'hA5);
    push(0, 1, 16'h00A5);
    do_req(0, 0, 0, 17'h00010, 16'h0, lat0);
    check("br_lat", lat0, 2);

    // Wide round trip on requester 1
    w0 = we_cnt;
    push(1, 0, 16'h0);
    do_req(1, 1, 1, 17'h00100, 16'h1234, lat1);
    check("ww_lat", lat1, 3);
    check("ww_wecycles", we_cnt - w0, 2);
    check("ww_hi", {24'd0, mem[17'h00100]}, 32'h12);
    check("ww_lo", {24'd0, mem[17'h00101]}, 32'h34);
    push(1, 1, 16'h1234);
    do_req(1, 0, 1, 17'h00100, 16'h0, lat1);
    check("wr_lat", lat1, 3);

    // Address wrap
    push(0, 0, 16'h0);
    do_req(0, 1, 1, 17'h1FFFF, 16'hBEEF, lat0);
    check("wrap_hi", {24'd0, mem[17'h1FFFF]}, 32'hBE);
    check("wrap_lo", {24'd0, mem[17'h00000]}, 32'hEF);
    push(0, 1, 16'hBEEF);
    do_req(0, 0, 1, 17'h1FFFF, 16'h0, lat0);

    // Reset during A1 of a wide write
    @(posedge clk); #1;
    we[0] = 1'b1; wide[0] = 1'b1; addr[0] = 17'h00200; wdata[0] = 16'hCAFE;
    req[0] = 1'b1;
    @(posedge clk);           // accepted, A0
    @(posedge clk); #1;       // A1
    rst_n = 1'b0; req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_busy", {31'd0, busy_o}, 32'd0);
    check("rstmid_ack",  {30'd0, ack_o},  32'd0);
    check("rstmid_hi",   {24'd0, mem[17'h00200]}, 32'hCA);
    check("rstmid_lo",   {24'd0, mem[17'h00201]}, 32'h00);

    // Late request arriving while requester 1 is in A1
    @(posedge clk); #1;
    push(1, 1, 16'h1234);
    push(0, 1, 16'h00A5);
    fork
      do_req(1, 0, 1, 17'h00100, 16'h0, lat1);
      begin
        @(posedge clk); @(posedge clk); #1;
        do_req(0, 0, 0, 17'h00010, 16'h0, lat0);
      end
    join
    check("late_r1_lat", lat1, 3);
    check("late_r0_lat", lat0, 4);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang want=finish");
    $fatal(1, "timeout");
  end

endmodule
